// File: rtl/bidirect_shift_reg_if.sv
// rtl/bidirect_shift_reg_if.sv - mode, serial, parallel and output signals of the universal shift register
interface bidirect_shift_reg_if #(
   parameter int WIDTH = 4
);
   logic             S1;
   logic             S0;
   logic             DSR;
   logic             DSL;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;

   modport master (
      output S1, S0, DSR, DSL, D,
      input  Q
   );

   modport slave (
      input  S1, S0, DSR, DSL, D,
      output Q
   );
endinterface

// File: rtl/bidirect_shift_reg.sv
// rtl/bidirect_shift_reg.sv - 74HC194-style 4-bit universal bidirectional shift register
// Q[0] is QA (shift-right entry), Q[WIDTH-1] is QD (shift-left entry); CR clears asynchronously.
module bidirect_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic                 CP,
   input  logic                 CR,
   bidirect_shift_reg_if.slave  bus
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] next_q;

   // Unknown mode bits fall into the default branch and hold.
   always_comb begin
      next_q = q;
      case ({bus.S1, bus.S0})
         2'b01:   next_q = {q[WIDTH-2:0], bus.DSR};
         2'b10:   next_q = {bus.DSL, q[WIDTH-1:1]};
         2'b11:   next_q = bus.D;
         default: next_q = q;
      endcase
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         q <= '0;
      end else begin
         q <= next_q;
      end
   end

   assign bus.Q = q;

endmodule

// File: tb/tb_bidirect_shift_reg.sv
// tb/tb_bidirect_shift_reg.sv - directed and random checks of bidirect_shift_reg against an arithmetic model
module tb_bidirect_shift_reg;

   logic cp;
   logic cr;
   int   checks;
   int   failures;
   int   m;

   bidirect_shift_reg_if #(.WIDTH(4)) bif ();

   bidirect_shift_reg #(.WIDTH(4)) dut (
      .CP  (cp),
      .CR  (cr),
      .bus (bif)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic check(input string tag, input logic [3:0] exp);
      checks++;
      assert (bif.Q === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, bif.Q, exp);
      end
   endtask

   // Apply inputs, take one rising edge, advance the model and compare.
   task automatic step(input string tag, input logic [1:0] mode, input logic dsr,
                       input logic dsl, input logic [3:0] d);
      bif.S1  = mode[1];
      bif.S0  = mode[0];
      bif.DSR = dsr;
      bif.DSL = dsl;
      bif.D   = d;
      @(posedge cp);
      #1;
      if (cr) begin
         case (mode)
            2'd1:    m = ((m * 2) + int'(dsr)) % 16;
            2'd2:    m = (m / 2) + 8 * int'(dsl);
            2'd3:    m = int'(d);
            default: m = m;
         endcase
      end else begin
         m = 0;
      end
      check(tag, m[3:0]);
   endtask

   task automatic clear_pulse(input string tag);
      cr = 1'b0;
      #1;
      m = 0;
      check(tag, 4'b0000);
      #1;
      cr = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m        = 0;
      cr       = 1'b0;
      bif.S1   = 1'b0;
      bif.S0   = 1'b0;
      bif.DSR  = 1'b0;
      bif.DSL  = 1'b0;
      bif.D    = 4'b0000;
      #1;
      check("reset_value", 4'b0000);
      @(negedge cp);
      cr = 1'b1;

      // Load then clear
      step("load_1111", 2'b11, 1'b0, 1'b0, 4'b1111);
      check("load_1111_lit", 4'b1111);
      clear_pulse("clear_after_load");
      cr = 1'b0;
      step("clear_held_edge1", 2'b11, 1'b1, 1'b1, 4'b1111);
      step("clear_held_edge2", 2'b01, 1'b1, 1'b1, 4'b1010);
      check("clear_held_lit", 4'b0000);
      cr = 1'b1;

      // Shift left with D=1111 held
      step("shl_1", 2'b10, 1'b1, 1'b1, 4'b1111);
      check("shl_1_lit", 4'b1000);
      step("shl_2", 2'b10, 1'b1, 1'b0, 4'b1111);
      check("shl_2_lit", 4'b0100);
      step("shl_3", 2'b10, 1'b0, 1'b1, 4'b1111);
      check("shl_3_lit", 4'b1010);
      step("shl_4", 2'b10, 1'b1, 1'b0, 4'b1111);
      check("shl_4_lit", 4'b0101);

      // Shift right with DSL toggling
      step("shr_1", 2'b01, 1'b1, 1'b0, 4'b0000);
      check("shr_1_lit", 4'b1011);
      step("shr_2", 2'b01, 1'b0, 1'b1, 4'b1111);
      check("shr_2_lit", 4'b0110);
      step("shr_3", 2'b01, 1'b1, 1'b0, 4'b0000);
      check("shr_3_lit", 4'b1101);
      step("shr_4", 2'b01, 1'b0, 1'b1, 4'b1111);
      check("shr_4_lit", 4'b1010);

      // Hold while everything else toggles
      step("hold_1", 2'b00, 1'b1, 1'b1, 4'b0101);
      step("hold_2", 2'b00, 1'b0, 1'b0, 4'b1111);
      step("hold_3", 2'b00, 1'b1, 1'b0, 4'b0000);
      check("hold_lit", 4'b1010);

      // Async clear mid-shift from 1101
      step("pre_load", 2'b11, 1'b0, 1'b0, 4'b0110);
      step("pre_shr", 2'b01, 1'b1, 1'b0, 4'b0000);
      check("pre_shr_lit", 4'b1101);
      clear_pulse("clear_mid_shift");
      step("post_clear_shr", 2'b01, 1'b1, 1'b0, 4'b0000);
      check("post_clear_shr_lit", 4'b0001);

      // Load priority over serial inputs
      clear_pulse("clear_before_load");
      step("load_prio", 2'b11, 1'b1, 1'b1, 4'b0110);
      check("load_prio_lit", 4'b0110);

      // Boundary: ones shifted out are lost
      step("load_edge", 2'b11, 1'b0, 1'b0, 4'b1001);
      step("shr_drop", 2'b01, 1'b0, 1'b1, 4'b1111);
      check("shr_drop_lit", 4'b0010);
      step("shl_drop_a", 2'b10, 1'b1, 1'b0, 4'b1111);
      step("shl_drop_b", 2'b10, 1'b1, 1'b0, 4'b1111);
      check("shl_drop_lit", 4'b0000);

      // Random mix including occasional async clear
      for (int i = 0; i < 300; i++) begin
         step("rand_step", 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              4'($urandom));
         if ($urandom_range(0, 19) == 0) begin
            clear_pulse("rand_clear");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
